booth_mul_seq: RTL and testbench
================================

// Module: booth_mul_seq
// PURPOSE
//  Sequential radix-2 Booth multiplier: W x W two's-complement operands -> 2W-bit product.
//  Consumes the carry-lookahead add/sub stage as its datapath.
//  One add/sub per cycle on a (W+1)-bit partial accumulator, then an arithmetic right shift.
//  Sits downstream of operand registers; feeds result/writeback logic.
// PARAMETERS
//  W   4   operand width in bits (W >= 2); product width is 2W
// PORTS
//  clk    in   1    clock, rising edge
//  rst    in   1    reset, asynchronous, active-high
//  start  in   1    start request; sampled only when not busy
//  A      in   W    multiplicand, captured on accepted start
//  B      in   W    multiplier, captured on accepted start
//  busy   out  1    high while iterating
//  done   out  1    one-cycle pulse: P is valid
//  P      out  2W   product; held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, P=0; internal regs (ACC, Q, q_1, MC, cnt) cleared.
//  Asynchronous: takes effect immediately, including mid-operation. Partial result discarded.
//  FSM states: IDLE -> CALC -> DONE -> IDLE.
//  IDLE/DONE + start=1 at edge:
//   - MC <= sign-extended A (W+1 bits); Q <= B; ACC <= 0 (W+1 bits); q_1 <= 0; cnt <= W.
//   - Go to CALC.
//  CALC, every edge:
//   - {Q[0],q_1}=01: ACC+MC. =10: ACC-MC. =00/11: ACC unchanged.
//   - Add/sub uses an instantiated CLA add/sub of width W+1; mode input = 1 selects subtract.
//   - Then arithmetic shift right of {ACC,Q,q_1} by 1; ACC MSB is replicated.
//   - cnt <= cnt-1. When cnt==1 this edge, next state is DONE.
//   - W+1-bit ACC makes MC = -2^(W-1) safe (no lost sign).
//   - The add/sub carry and overflow outputs are ignored.
//  DONE (one cycle):
//   - done=1; P = {ACC[W-1:0], Q} registered on the CALC->DONE edge.
//   - Next state IDLE unless start=1, which restarts as in IDLE.
//  Outputs:
//   - busy=1 exactly in CALC.
//   - Latency: start sampled at edge 0 -> busy for W cycles -> done high in the cycle after edge W.
//   - Throughput: one product per W+1 cycles.
//  start while busy: ignored; operands are not re-captured and the result is unaffected.
//  A/B may change freely after the start edge.
//  P changes only on the CALC->DONE edge or on reset.
// CONFIGURATION
//  MUL_UNSIGNED_EN defined:
//   - Adds input port 'uns' (1 bit), sampled with start.
//   - uns=1: A zero-extended into MC; Q widened with a leading 0; W+1 iterations (latency W+1).
//   - uns=1 result: P = unsigned A*B.
//   - uns=0: identical to the signed behaviour.
//  MUL_UNSIGNED_EN undefined:
//   - No 'uns' port; signed only; always W iterations.
// TESTING (W=4)
//  Reset, then start A=3, B=5 -> done pulse after 4 busy cycles, P=8'h0F; P held afterwards.
//  Signed corners:
//   - A=-8, B=-8 -> P=8'h40.
//   - A=-8, B=7 -> P=8'hC8.
//   - A=7, B=-1 -> P=8'hF9.
//   - A=0, B=-5 -> P=8'h00.
//  Start pulsed during CALC with A=1, B=1 after an initial 2*3 -> P=8'h06, single done, busy stays 4 cycles.
//  Back-to-back: start held high through DONE; 2*2 then 3*3 -> P=8'h04 then 8'h09, no idle cycle between.
//  rst asserted mid-CALC -> busy=0, done=0, P=0 immediately.
//   - Following start 6*-2 -> P=8'hF4.
//  MUL_UNSIGNED_EN:
//   - uns=1, A=15, B=15 -> P=8'hE1 after 5 busy cycles.
//   - uns=0, same operands -> P=8'h01.

Source files
------------

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-2 Booth multiplier, W x W -> 2W, on a CLA add/sub stage.
// Optional MUL_UNSIGNED_EN adds an 'uns' input for unsigned products (one extra iteration).

module booth_cla_addsub #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         mode,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   logic [N-1:0] bx;
   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         cc;
   logic         pp;

   // Each carry is expanded from the generate/propagate terms directly, not rippled.
   always_comb begin
      bx   = b ^ {N{mode}};
      g    = a & bx;
      p    = a ^ bx;
      c    = '0;
      cc   = 1'b0;
      pp   = 1'b0;
      c[0] = mode;
      for (int i = 0; i < N; i++) begin
         cc = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            cc = cc | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = cc | (pp & mode);
      end
      sum  = p ^ c[N-1:0];
      cout = c[N];
      ovf  = c[N] ^ c[N-1];
   end
endmodule

module booth_mul_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
`ifdef MUL_UNSIGNED_EN
   input  logic           uns,
`endif
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] P
);
   localparam int AW = W + 1;
`ifdef MUL_UNSIGNED_EN
   localparam int QW = W + 1;
`else
   localparam int QW = W;
`endif
   localparam int CW = $clog2(W + 2);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [AW-1:0]  acc;
   logic [QW-1:0]  q;
   logic           q_1;
   logic [AW-1:0]  mc;
   logic [CW-1:0]  cnt;
`ifdef MUL_UNSIGNED_EN
   logic           uns_r;
`endif

   logic [AW-1:0]  as_sum;
   logic [1:0]     addsub_unused;
   logic [AW-1:0]  acc_op;
   logic [AW-1:0]  acc_n;
   logic [QW-1:0]  q_n;
   logic           q1_n;
   logic [2*W-1:0] prod_n;

   // Booth pair 10 subtracts the multiplicand, 01 adds it.
   booth_cla_addsub #(.N(AW)) u_addsub (
      .a    (acc),
      .b    (mc),
      .mode (q[0] & ~q_1),
      .sum  (as_sum),
      .cout (addsub_unused[1]),
      .ovf  (addsub_unused[0])
   );

   always_comb begin
      acc_op = (q[0] ^ q_1) ? as_sum : acc;
      acc_n  = {acc_op[AW-1], acc_op[AW-1:1]};
      q_n    = {acc_op[0], q[QW-1:1]};
      q1_n   = q[0];
`ifdef MUL_UNSIGNED_EN
      // Signed runs stop one shift short, so the zero pad still sits in q_n[0].
      if (uns_r)
         prod_n = {acc_n[W-2:0], q_n};
      else
         prod_n = {acc_n[W-1:0], q_n[QW-1:1]};
`else
      prod_n = {acc_n[W-1:0], q_n};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         P     <= '0;
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         mc    <= '0;
         cnt   <= '0;
`ifdef MUL_UNSIGNED_EN
         uns_r <= 1'b0;
`endif
      end else begin
         case (state)
            CALC: begin
               acc <= acc_n;
               q   <= q_n;
               q_1 <= q1_n;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  P     <= prod_n;
               end
            end
            default: begin
               done <= 1'b0;
               if (start) begin
                  state <= CALC;
                  busy  <= 1'b1;
                  acc   <= '0;
                  q_1   <= 1'b0;
`ifdef MUL_UNSIGNED_EN
                  uns_r <= uns;
                  mc    <= uns ? {1'b0, A} : {A[W-1], A};
                  q     <= {1'b0, B};
                  cnt   <= uns ? CW'(W + 1) : CW'(W);
`else
                  mc    <= {A[W-1], A};
                  q     <= B;
                  cnt   <= CW'(W);
`endif
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard bench for booth_mul_seq at W=4.

module tb_booth_mul_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic       uns = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] P;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int busy_run = 0;
   logic [7:0] exp_q[$];
   int         lat_q[$];

   booth_mul_seq #(.W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef MUL_UNSIGNED_EN
      .uns   (uns),
`endif
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic u);
      logic signed [3:0] sa;
      logic signed [3:0] sb;
      logic signed [7:0] sp;
      logic [7:0]        up;
      sa = a;
      sb = b;
      sp = sa * sb;
      up = {4'b0, a} * {4'b0, b};
      return u ? up : sp;
   endfunction

   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic u);
      exp_q.push_back(model(a, b, u));
      lat_q.push_back(u ? 5 : 4);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", 16'd1, 16'd0);
            end else begin
               check("P", {8'h0, P}, {8'h0, exp_q.pop_front()});
               check("busy_cycles", busy_run[15:0], lat_q.pop_front());
            end
            busy_run = 0;
            done_cnt++;
         end
      end
   end

   task automatic wait_done(input int n0);
      for (int i = 0; i < 20 && done_cnt == n0; i++) begin
         @(negedge clk);
         #1;
      end
      if (done_cnt == n0) check("timeout", 16'd0, 16'd1);
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic u);
      int n0;
      @(negedge clk);
      n0 = done_cnt;
      A = a;
      B = b;
      uns = u;
      start = 1'b1;
      push(a, b, u);
      @(posedge clk);
      #1;
      start = 1'b0;
      A = ~a;
      B = ~b;
      wait_done(n0);
   endtask

   initial begin
      int n0;
      logic [3:0] ta [4];
      logic [3:0] tb [4];
      ta = '{4'h8, 4'h8, 4'h7, 4'h0};
      tb = '{4'h8, 4'h7, 4'hF, 4'hB};

      repeat (2) @(negedge clk);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_P", {8'h0, P}, 16'h0);
      rst = 1'b0;

      run_op(4'd3, 4'd5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("P_held", {8'h0, P}, 16'h000F);
      end

      for (int i = 0; i < 4; i++) run_op(ta[i], tb[i], 1'b0);

      // A second start mid-calculation must be ignored.
      @(negedge clk);
      n0 = done_cnt;
      A = 4'd2; B = 4'd3; start = 1'b1;
      push(4'd2, 4'd3, 1'b0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); #1;
      A = 4'd1; B = 4'd1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(n0);
      repeat (6) @(negedge clk);

      // Back-to-back with start held through DONE.
      @(negedge clk);
      n0 = done_cnt;
      A = 4'd2; B = 4'd2; start = 1'b1;
      push(4'd2, 4'd2, 1'b0);
      @(posedge clk); #1;
      A = 4'd3; B = 4'd3;
      push(4'd3, 4'd3, 1'b0);
      wait_done(n0);
      n0 = done_cnt;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("b2b_busy", {15'd0, busy}, 16'd1);
      wait_done(n0);

      // Asynchronous reset mid-calculation.
      @(negedge clk);
      A = 4'd7; B = 4'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); #2 rst = 1'b1;
      #1;
      check("arst_busy", {15'd0, busy}, 16'd0);
      check("arst_done", {15'd0, done}, 16'd0);
      check("arst_P", {8'h0, P}, 16'h0);
      @(negedge clk); #2 rst = 1'b0;
      run_op(4'd6, 4'hE, 1'b0);

`ifdef MUL_UNSIGNED_EN
      run_op(4'hF, 4'hF, 1'b1);
      run_op(4'hF, 4'hF, 1'b0);
`endif

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
